// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped UART responder on the core's data-memory port.
//
// Register window (decode: mem_addr_i[31:4] == BASE_ADDR[31:4], offset [3:2]):
//   0x0 DATA    write pushes [7:0] into the TX FIFO (dropped when full);
//               read returns {24'b0, rx_byte} and clears rx_valid
//   0x4 STATUS  {frame_err, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full};
//               rx_overrun and frame_err are sticky, cleared by a STATUS read
//   0x8 DIVISOR [15:0] clock cycles per bit; 0 is stored as 1; each FSM
//               picks up a new value only at the start of its next frame
//   0xC CTRL    [0] loopback enable when UART_LOOPBACK_EN is defined, else 0
//
// Optional feature macro: UART_LOOPBACK_EN (RX fed from the TX shifter,
// uart_tx_o held high while CTRL[0] is set).
//
// Ports:
//   clk, rst_n   single clock domain, asynchronous active-low reset
//   wmem_en_i    write strobe from the core MEM stage
//   rmem_en_i    read strobe from the core MEM stage
//   mem_addr_i   byte address
//   wmem_data_i  write data
//   rmem_data_o  combinational read data, 0 when the window is not selected
//   uart_tx_o    serial out, idles high
//   uart_rx_i    serial in, asynchronous to clk
module mmio_uart #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wmem_en_i,
    input  logic        rmem_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] wmem_data_i,
    output logic [31:0] rmem_data_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);

    localparam int unsigned    AW         = $clog2(TX_DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(TX_DEPTH);
    localparam logic [15:0]    DIV_RESET  = 16'(CLK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------------------------------------------------------- decode
    logic       sel;
    logic [1:0] off;
    logic       data_wr, div_wr, data_rd, status_rd;

    assign sel       = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign off       = mem_addr_i[3:2];
    assign data_wr   = sel & wmem_en_i & (off == 2'd0);
    assign div_wr    = sel & wmem_en_i & (off == 2'd2);
    assign data_rd   = sel & rmem_en_i & (off == 2'd0);
    assign status_rd = sel & rmem_en_i & (off == 2'd1);

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr_i[1:0], wmem_data_i[31:16]};

    // --------------------------------------------------------------- divisor
    logic [15:0] div_reg;

    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from pre-edge values; blocking (=) here would
    // make results depend on statement and block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_reg <= DIV_RESET;
        else if (div_wr)
            div_reg <= (wmem_data_i[15:0] == 16'd0) ? 16'd1 : wmem_data_i[15:0];
    end

    // --------------------------------------------------------------- TX FIFO
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          tx_full, tx_empty, push, tx_load;

    assign tx_full  = (count == FULL_COUNT);
    assign tx_empty = (count == '0);
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign push     = data_wr & (!tx_full | tx_load);

    // NOTE: the FIFO storage has no reset; the pointers and count define which
    // entries are valid, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wmem_data_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (tx_load)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, tx_load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- TX FSM
    state_t      tx_state;
    logic [7:0]  tx_shift;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic        tx_q, tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == tx_div - 16'd1);
    assign tx_busy = (tx_state != S_IDLE);
    // Load a new frame from IDLE, or straight out of STOP for gapless frames.
    assign tx_load = !tx_empty &&
                     ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_q     <= 1'b1;
        end else if (tx_load) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_div   <= div_reg;
            tx_cnt   <= '0;
            tx_q     <= 1'b0;
            tx_state <= S_START;
        end else begin
            unique case (tx_state)
                S_IDLE: ;
                S_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_q     <= tx_shift[0];
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_q     <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_q     <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_tick) begin
                        tx_cnt   <= '0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------- loopback / pin muxing
    logic        rx_src;
    logic [31:0] ctrl_rd;

`ifdef UART_LOOPBACK_EN
    logic lb_en;
    logic ctrl_wr;
    assign ctrl_wr = sel & wmem_en_i & (off == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lb_en <= 1'b0;
        else if (ctrl_wr)
            lb_en <= wmem_data_i[0];
    end

    assign rx_src    = lb_en ? tx_q : uart_rx_i;
    assign uart_tx_o = lb_en ? 1'b1 : tx_q;
    assign ctrl_rd   = {31'b0, lb_en};
`else
    assign rx_src    = uart_rx_i;
    assign uart_tx_o = tx_q;
    assign ctrl_rd   = 32'b0;
`endif

    // ---------------------------------------------------------------- RX FSM
    // rx_s1/rx_s2 synchronise the pin; rx_s3 is the previous synced value for
    // start-edge detection.
    logic        rx_s1, rx_s2, rx_s3;
    state_t      rx_state;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_stop_sample, rx_done, rx_ferr;

    assign rx_stop_sample = (rx_state == S_STOP) && (rx_cnt == rx_div);
    assign rx_done        = rx_stop_sample & rx_s2;
    assign rx_ferr        = rx_stop_sample & !rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_src;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // rx_cnt counts cycles since the last event starting at 1, so a sample
    // lands when rx_cnt reaches div (div/2 for the start-bit check).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            unique case (rx_state)
                S_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_cnt   <= 16'd1;
                        rx_div   <= div_reg;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt >= (rx_div >> 1)) begin
                        rx_cnt   <= 16'd1;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == rx_div) begin
                        rx_cnt   <= 16'd1;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= S_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_stop_sample)
                        rx_state <= S_IDLE;
                    else
                        rx_cnt <= rx_cnt + 16'd1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------ RX holding and status
    logic [7:0] rx_byte;
    logic       rx_valid, rx_overrun, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Clear first so a new error in the same cycle is not lost.
            if (status_rd) begin
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            if (rx_ferr)
                frame_err <= 1'b1;
            if (rx_done) begin
                // A DATA read in the same cycle makes room for the new byte.
                if (!rx_valid || data_rd) begin
                    rx_byte  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------- read mux
    // NOTE: the output gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        rmem_data_o = 32'b0;
        if (sel) begin
            unique case (off)
                2'd0: rmem_data_o = {24'b0, rx_byte};
                2'd1: rmem_data_o = {26'b0, frame_err, tx_busy, rx_overrun,
                                     rx_valid, tx_empty, tx_full};
                2'd2: rmem_data_o = {16'b0, div_reg};
                2'd3: rmem_data_o = ctrl_rd;
                default: rmem_data_o = 32'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart.sv
// Directed testbench for mmio_uart: one task per scenario, each with inline
// comparisons against hand-derived values.
module tb_mmio_uart;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wmem_en = 1'b0;
    logic        rmem_en = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] wmem_data = 32'h0;
    logic [31:0] rmem_data;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int total = 0;
    int bad   = 0;

    mmio_uart dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wmem_en_i  (wmem_en),
        .rmem_en_i  (rmem_en),
        .mem_addr_i (mem_addr),
        .wmem_data_i(wmem_data),
        .rmem_data_o(rmem_data),
        .uart_tx_o  (uart_tx),
        .uart_rx_i  (uart_rx)
    );

    always #5 clk = ~clk;

    // All tasks start and end 1 ns after a rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        wmem_data = d;
        wmem_en   = 1'b1;
        @(posedge clk); #1;
        wmem_en   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        mem_addr = a;
        rmem_en  = 1'b1;
        #2;
        d = rmem_data;
        @(posedge clk); #1;
        rmem_en  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Line level of a UART frame in bit slot 0 (start) .. 9 (stop).
    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        for (int s = 0; s < 10; s++) begin
            uart_rx = (s == 9) ? stop : frame_bit(b, s);
            repeat (div) begin
                @(posedge clk); #1;
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        wait_cycles(3);
        total++;
        if (uart_tx !== 1'b1) begin
            bad++; $display("FAIL reset_tx: got %b want 1", uart_tx);
        end
        rst_n = 1'b1;
        wait_cycles(1);
        mem_addr = 32'h0; rmem_en = 1'b1; #2;
        total++;
        if (rmem_data !== 32'h0) begin
            bad++; $display("FAIL unselected_read: got %h want 0", rmem_data);
        end
        @(posedge clk); #1; rmem_en = 1'b0;
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL reset_status: got %h want 2", rd); end
        bus_read(A_DIV, rd); total++;
        if (rd !== 32'd434) begin bad++; $display("FAIL reset_div: got %0d want 434", rd); end
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", rd); end
        bus_read(A_CTRL, rd); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", rd); end
    endtask

    task automatic test_tx_frame;
        logic [31:0] rd;
        logic        exp_tx, exp_busy;
        int          busy_cycles;
        bus_write(A_DIV, 32'd4);
        bus_read(A_DIV, rd); total++;
        if (rd !== 32'd4) begin bad++; $display("FAIL div_write: got %0d want 4", rd); end
        bus_write(A_DATA, 32'h55);
        mem_addr = A_STAT; rmem_en = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            exp_tx   = (k >= 1 && k <= 40) ? frame_bit(8'h55, (k - 1) / 4) : 1'b1;
            exp_busy = (k >= 1 && k <= 40);
            if (rmem_data[4]) busy_cycles++;
            total++;
            if (uart_tx !== exp_tx) begin
                bad++; $display("FAIL tx_55 cycle %0d: got %b want %b", k, uart_tx, exp_tx);
            end
            total++;
            if (rmem_data[4] !== exp_busy) begin
                bad++; $display("FAIL tx_busy cycle %0d: got %b want %b", k, rmem_data[4], exp_busy);
            end
        end
        rmem_en = 1'b0;
        total++;
        if (busy_cycles != 40) begin
            bad++; $display("FAIL tx_busy_len: got %0d want 40", busy_cycles);
        end
    endtask

    // Writes 0x00..0x08 on consecutive edges, then 0x09 while full. The first
    // byte is popped one edge after it lands, so all nine fit and 0x09 drops.
    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        exp_tx;
        int          f;
        for (int c = 0; c <= 380; c++) begin
            if (c <= 8 || c == 10) begin
                mem_addr = A_DATA; wmem_data = (c == 10) ? 32'h9 : c; wmem_en = 1'b1; rmem_en = 1'b0;
            end else begin
                wmem_en = 1'b0; mem_addr = A_STAT; rmem_en = 1'b1;
            end
            if (c == 9 || c == 11) begin
                #1; total++;
                if (rmem_data[0] !== 1'b1) begin
                    bad++; $display("FAIL b2b_full at %0d: got %b want 1", c, rmem_data[0]);
                end
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 360) begin
                f = (c - 1) / 40;
                exp_tx = frame_bit(8'(f), ((c - 1) % 40) / 4);
            end else begin
                exp_tx = 1'b1;
            end
            total++;
            if (uart_tx !== exp_tx) begin
                bad++; $display("FAIL b2b_tx cycle %0d: got %b want %b", c, uart_tx, exp_tx);
            end
        end
        wmem_en = 1'b0; rmem_en = 1'b0;
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL b2b_end_status: got %h want 2", rd); end
    endtask

    task automatic test_rx_frame;
        logic [31:0] rd;
        send_rx(8'hA3, 1'b1, 4);
        wait_cycles(4);
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h6) begin bad++; $display("FAIL rx_valid_status: got %h want 6", rd); end
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'hA3) begin bad++; $display("FAIL rx_data: got %h want a3", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL rx_cleared: got %h want 2", rd); end
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'hA3) begin bad++; $display("FAIL rx_stale: got %h want a3", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL rx_stale_status: got %h want 2", rd); end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] rd;
        send_rx(8'h11, 1'b1, 4);
        send_rx(8'h22, 1'b1, 4);
        wait_cycles(4);
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'h11) begin bad++; $display("FAIL ovr_data: got %h want 11", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'hA) begin bad++; $display("FAIL ovr_status1: got %h want a", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL ovr_status2: got %h want 2", rd); end
    endtask

    task automatic test_frame_err_glitch;
        logic [31:0] rd;
        send_rx(8'h5A, 1'b0, 4);
        wait_cycles(4);
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h22) begin bad++; $display("FAIL ferr_status1: got %h want 22", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL ferr_status2: got %h want 2", rd); end
        uart_rx = 1'b0;
        wait_cycles(1);
        uart_rx = 1'b1;
        wait_cycles(12);
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL glitch_status: got %h want 2", rd); end
        send_rx(8'h3C, 1'b1, 4);
        wait_cycles(4);
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'h3C) begin bad++; $display("FAIL after_glitch_data: got %h want 3c", rd); end
    endtask

    task automatic test_decode_divisor;
        logic [31:0] rd;
        send_rx(8'h77, 1'b1, 4);
        wait_cycles(4);
        bus_read(BASE + 32'h10, rd); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL outside_read: got %h want 0", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h6) begin bad++; $display("FAIL outside_no_side_effect: got %h want 6", rd); end
        bus_write(BASE + 32'h18, 32'd9);
        bus_read(A_DIV, rd); total++;
        if (rd !== 32'd4) begin bad++; $display("FAIL outside_write: got %0d want 4", rd); end
        mem_addr = A_DIV; wmem_data = 32'd7; wmem_en = 1'b1; rmem_en = 1'b1;
        #2; total++;
        if (rmem_data !== 32'd4) begin bad++; $display("FAIL rw_same_cycle: got %0d want 4", rmem_data); end
        @(posedge clk); #1; wmem_en = 1'b0; rmem_en = 1'b0;
        bus_read(A_DIV, rd); total++;
        if (rd !== 32'd7) begin bad++; $display("FAIL rw_write_took: got %0d want 7", rd); end
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, rd); total++;
        if (rd !== 32'd1) begin bad++; $display("FAIL div_zero: got %0d want 1", rd); end
        bus_write(A_DIV, 32'd4);
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'h77) begin bad++; $display("FAIL decode_data: got %h want 77", rd); end
    endtask

    task automatic test_loopback;
        logic [31:0] rd;
`ifdef UART_LOOPBACK_EN
        int low_seen;
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, rd); total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL lb_ctrl: got %h want 1", rd); end
        bus_write(A_DATA, 32'h3C);
        low_seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) low_seen++;
        end
        total++;
        if (low_seen != 0) begin bad++; $display("FAIL lb_tx_held: got %0d low cycles want 0", low_seen); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h6) begin bad++; $display("FAIL lb_status: got %h want 6", rd); end
        bus_read(A_DATA, rd); total++;
        if (rd !== 32'h3C) begin bad++; $display("FAIL lb_data: got %h want 3c", rd); end
        bus_write(A_CTRL, 32'h0);
`else
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, rd); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL ctrl_absent: got %h want 0", rd); end
`endif
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] rd;
        bus_write(A_DATA, 32'h00);
        wait_cycles(10);
        total++;
        if (uart_tx !== 1'b0) begin bad++; $display("FAIL mid_frame_low: got %b want 0", uart_tx); end
        #2; rst_n = 1'b0;
        #1; total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
        @(posedge clk); #1; rst_n = 1'b1;
        wait_cycles(1);
        bus_read(A_DIV, rd); total++;
        if (rd !== 32'd434) begin bad++; $display("FAIL mid_reset_div: got %0d want 434", rd); end
        bus_read(A_STAT, rd); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL mid_reset_status: got %h want 2", rd); end
        wait_cycles(20);
        total++;
        if (uart_tx !== 1'b1) begin bad++; $display("FAIL mid_reset_idle: got %b want 1", uart_tx); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_frame();
        test_rx_overrun();
        test_frame_err_glitch();
        test_decode_divisor();
        test_loopback();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
